// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART control blocks: arbiter FSM states
// and the round-robin pick used by rr_arbiter.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;
    localparam int MAX_REQ     = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SEND    = 2'd1,
        ARB_RECOVER = 2'd2
    } arb_state_t;

    // Returns the first set bit of req searching upward from ptr+1, wrapping
    // modulo n; returns ptr when req is empty.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [3:0] win;
        int         idx;
        win = ptr;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(ptr) + i) % n;
            if (req[idx]) win = 4'(idx);
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client and transmitter signals of the shared UART TX arbiter.
// master = arbiter side, slave = clients/transmitter side.
interface uart_tx_arbiter_if
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_send;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      busy;
    logic                      tx_timeout;

    modport master (
        input  req, req_data, tx_done,
        output gnt, ack, tx_send, tx_data, busy, tx_timeout
    );

    modport slave (
        output req, req_data, tx_done,
        input  gnt, ack, tx_send, tx_data, busy, tx_timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search from rr_ptr+1 and a
// registered pointer that moves to the winner when update is asserted.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          update,
    output logic [IW-1:0] winner,
    output logic          valid
);
    logic [IW-1:0]      rr_ptr;
    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, 4'(rr_ptr), N);
    end

    assign winner = IW'(pick);
    assign valid  = |req;

    // Reset to the last index so index 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= IW'(N - 1);
        else if (update) rr_ptr <= winner;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers (round robin) and
// sequences send/donetx. Optional SEND abort: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  DATA_W         = UART_DATA_W,
    parameter int  SYNC_STAGES    = 2,
    parameter int  TIMEOUT_CYCLES = 2000,
    localparam int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arbiter_if.master          bus
);
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_t             state;
    logic [SYNC_STAGES-1:0] done_sync;
    logic                   done_d;
    logic                   done_s;
    logic                   done_rise;
    logic                   done_fall;
    logic [IW-1:0]          winner;
    logic                   arb_valid;
    logic                   grant_now;

    // tx_done comes from the transmitter's divided clock; treat as async.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_sync <= '0;
            done_d    <= 1'b0;
        end else begin
            done_sync[0] <= bus.tx_done;
            for (int i = 1; i < SYNC_STAGES; i++) done_sync[i] <= done_sync[i-1];
            done_d <= done_sync[SYNC_STAGES-1];
        end
    end

    assign done_s    = done_sync[SYNC_STAGES-1];
    assign done_rise = done_s & ~done_d;
    assign done_fall = ~done_s & done_d;

    // Never grant while done is still high, else the transmitter would see
    // send before donetx clears and transmit twice.
    assign grant_now = (state == ARB_IDLE) && arb_valid && !done_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .update (grant_now),
        .winner (winner),
        .valid  (arb_valid)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ARB_IDLE;
            bus.gnt        <= '0;
            bus.ack        <= '0;
            bus.tx_send    <= 1'b0;
            bus.tx_data    <= '0;
            bus.busy       <= 1'b0;
            bus.tx_timeout <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            bus.ack        <= '0;
            bus.tx_timeout <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_now) begin
                        bus.tx_data <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
                        bus.gnt     <= NUM_REQ'(1) << winner;
                        bus.tx_send <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= ARB_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                ARB_SEND: begin
                    if (done_rise) begin
                        bus.tx_send <= 1'b0;
                        bus.ack     <= bus.gnt;
                        state       <= ARB_RECOVER;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        bus.tx_send    <= 1'b0;
                        bus.tx_timeout <= 1'b1;
                        state          <= ARB_RECOVER;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end
                ARB_RECOVER: begin
                    if (done_fall || !done_s) begin
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        state    <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
